// File: rtl/sobel_core.sv
// Sobel edge-magnitude engine behind the frame row cache.
// Reads three-row words, writes packed 8-bit magnitudes back in raster order.
module sobel_core #(
    parameter int WIDTH  = 352,
    parameter int HEIGHT = 288,
    parameter int RD_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        cache_en,
    output logic        cache_we,
    output logic [31:0] cache_di,
    input  logic [31:0] doa,
    input  logic [31:0] dob,
    input  logic [31:0] doc,
    output logic        finish
);
    localparam int WPR = WIDTH / 4;
    localparam int NW  = WPR * HEIGHT;
    localparam int CW  = $clog2(WPR);
    localparam int RW  = $clog2(HEIGHT);
    localparam int AW  = $clog2(NW + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WPR - 1);
    localparam logic [AW-1:0] RD_LAST  = AW'(NW - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ZTOP  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_ZBOT  = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              en_q, en_d, we_q, we_d;
    logic              finish_q, finish_d, phase_q, phase_d;
    logic [31:0]       di_q, di_d;
    logic [CW-1:0]     zcnt_q, zcnt_d, col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [AW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [31:0]       ca_q, ca_d, cb_q, cb_d, cc_q, cc_d;
    logic [7:0]        la_q, la_d, lb_q, lb_d, lc_q, lc_d;
    logic [31:0]       ob0_q, ob0_d, ob1_q, ob1_d;
    logic [1:0]        cnt_q, cnt_d, n;
    logic              arr, in_flight, pop, frame_go, push1, push2;
    logic [31:0]       out1, out2;

    assign busy     = busy_q;
    assign done     = done_q;
    assign cache_en = en_q;
    assign cache_we = we_q;
    assign cache_di = di_q;
    assign finish   = finish_q;

    function automatic logic [11:0] px(input logic [47:0] w, input int j);
        return {4'h0, w[47-8*j -: 8]};
    endfunction

    // Windows are {left pixel, 4 pixels, right pixel}, leftmost in the MSBs.
    function automatic logic [31:0] sobel4(input logic [47:0] t,
                                           input logic [47:0] m,
                                           input logic [47:0] b);
        logic [11:0] gx, gy, ax, ay, s;
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            gx = (px(t, i + 2) + (px(m, i + 2) << 1) + px(b, i + 2))
               - (px(t, i) + (px(m, i) << 1) + px(b, i));
            gy = (px(b, i) + (px(b, i + 1) << 1) + px(b, i + 2))
               - (px(t, i) + (px(t, i + 1) << 1) + px(t, i + 2));
            ax = gx[11] ? (12'd0 - gx) : gx;
            ay = gy[11] ? (12'd0 - gy) : gy;
            s  = ax + ay;
            r[31-8*i -: 8] = (s > 12'd255) ? 8'hFF : s[7:0];
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        finish_d = 1'b0;
        en_d     = 1'b0;
        we_d     = 1'b0;
        di_d     = '0;
        phase_d  = phase_q;
        zcnt_d   = zcnt_q;
        rd_cnt_d = rd_cnt_q;
        pop      = 1'b0;
        frame_go = 1'b0;
        in_flight = (|vld_q) | (en_q & ~we_q);
        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    frame_go = 1'b1;
                    busy_d   = 1'b1;
                    zcnt_d   = '0;
                    rd_cnt_d = '0;
                    state_d  = S_ZTOP;
                end
            end
            S_ZTOP: begin
                en_d   = 1'b1;
                we_d   = 1'b1;
                zcnt_d = zcnt_q + 1'b1;
                if (zcnt_q == COL_LAST) begin
                    zcnt_d  = '0;
                    phase_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                phase_d = ~phase_q;
                if (!phase_q) begin
                    en_d     = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == RD_LAST) state_d = S_DRAIN;
                end else if (cnt_q != 2'd0) begin
                    en_d = 1'b1;
                    we_d = 1'b1;
                    di_d = ob0_q;
                    pop  = 1'b1;
                end
            end
            S_DRAIN: begin
                phase_d = ~phase_q;
                if (phase_q && cnt_q != 2'd0) begin
                    en_d = 1'b1;
                    we_d = 1'b1;
                    di_d = ob0_q;
                    pop  = 1'b1;
                end
                if (!in_flight && cnt_q == 2'd0) begin
                    zcnt_d  = '0;
                    state_d = S_ZBOT;
                end
            end
            S_ZBOT: begin
                en_d   = 1'b1;
                we_d   = 1'b1;
                zcnt_d = zcnt_q + 1'b1;
                if (zcnt_q == COL_LAST) begin
                    zcnt_d  = '0;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done_d   = 1'b1;
                finish_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        arr = vld_q[RD_LAT-1];
        vld_d[0] = en_q & ~we_q;
        for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
        row_d = row_q;
        col_d = col_q;
        ca_d = ca_q;
        cb_d = cb_q;
        cc_d = cc_q;
        la_d = la_q;
        lb_d = lb_q;
        lc_d = lc_q;
        push1 = arr && (row_q >= RW'(2)) && (col_q != '0);
        push2 = arr && (row_q >= RW'(2)) && (col_q == COL_LAST);
        // out1 finishes the previous word; out2 is the row's last word.
        out1 = sobel4({la_q, ca_q, doa[31:24]},
                      {lb_q, cb_q, dob[31:24]},
                      {lc_q, cc_q, doc[31:24]});
        if (col_q == CW'(1)) out1[31:24] = 8'h00;
        out2 = sobel4({ca_q[7:0], doa, 8'h00},
                      {cb_q[7:0], dob, 8'h00},
                      {cc_q[7:0], doc, 8'h00});
        out2[7:0] = 8'h00;
        if (arr) begin
            ca_d = doa;
            cb_d = dob;
            cc_d = doc;
            la_d = ca_q[7:0];
            lb_d = cb_q[7:0];
            lc_d = cc_q[7:0];
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        n = cnt_q;
        ob0_d = ob0_q;
        ob1_d = ob1_q;
        if (pop) begin
            ob0_d = ob1_q;
            n = n - 2'd1;
        end
        if (push1) begin
            if (n == 2'd0) ob0_d = out1;
            else ob1_d = out1;
            n = n + 2'd1;
        end
        if (push2) begin
            if (n == 2'd0) ob0_d = out2;
            else ob1_d = out2;
            n = n + 2'd1;
        end
        cnt_d = n;
        if (frame_go) begin
            row_d = '0;
            col_d = '0;
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            di_q     <= '0;
            finish_q <= 1'b0;
            phase_q  <= 1'b0;
            zcnt_q   <= '0;
            rd_cnt_q <= '0;
            vld_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            ca_q     <= '0;
            cb_q     <= '0;
            cc_q     <= '0;
            la_q     <= '0;
            lb_q     <= '0;
            lc_q     <= '0;
            ob0_q    <= '0;
            ob1_q    <= '0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            en_q     <= en_d;
            we_q     <= we_d;
            di_q     <= di_d;
            finish_q <= finish_d;
            phase_q  <= phase_d;
            zcnt_q   <= zcnt_d;
            rd_cnt_q <= rd_cnt_d;
            vld_q    <= vld_d;
            row_q    <= row_d;
            col_q    <= col_d;
            ca_q     <= ca_d;
            cb_q     <= cb_d;
            cc_q     <= cc_d;
            la_q     <= la_d;
            lb_q     <= lb_d;
            lc_q     <= lc_d;
            ob0_q    <= ob0_d;
            ob1_q    <= ob1_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_sobel_core.sv
// Directed bench for sobel_core on a 16x4 frame with a
// behavioural row cache (three-row read port, sequential writes).
module tb_sobel_core;
    localparam int W   = 16;
    localparam int H   = 4;
    localparam int LAT = 3;
    localparam int WPR = W / 4;
    localparam int NW  = WPR * H;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, cache_en, cache_we, finish;
    logic [31:0] cache_di, doa, dob, doc;

    sobel_core #(.WIDTH(W), .HEIGHT(H), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cache_en(cache_en), .cache_we(cache_we), .cache_di(cache_di),
        .doa(doa), .dob(dob), .doc(doc), .finish(finish)
    );

    always #5 clk = ~clk;

    logic [7:0]  pix [H][W];
    logic [31:0] wmem [NW];
    logic [31:0] expv [NW];
    int          pa [LAT];
    int          rd_addr, wr_addr;
    int          mn, mr, mk;
    int          wcnt = 0, rcnt = 0, ndone = 0, nfin = 0;
    int          n_chk = 0, n_fail = 0;

    function automatic logic [31:0] row_word(input int r, input int k);
        if (r < 0 || r >= H) return '0;
        return {pix[r][4*k], pix[r][4*k+1], pix[r][4*k+2], pix[r][4*k+3]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pa[i] <= 0;
            rd_addr <= 0;
            wr_addr <= 0;
        end else begin
            pa[0] <= rd_addr;
            for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
            if (cache_en && !cache_we) rd_addr <= rd_addr + 1;
            if (cache_en && cache_we) begin
                if (wr_addr < NW) wmem[wr_addr] <= cache_di;
                wr_addr <= wr_addr + 1;
            end
            if (finish) begin
                rd_addr <= 0;
                wr_addr <= 0;
            end
        end
    end

    always_comb begin
        mn = pa[LAT-1];
        mr = mn / WPR;
        mk = mn % WPR;
        doc = row_word(mr, mk);
        dob = row_word(mr - 1, mk);
        doa = row_word(mr - 2, mk);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (cache_en && cache_we) wcnt++;
            if (cache_en && !cache_we) rcnt++;
            if (done) ndone++;
            if (finish) nfin++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_frame(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0: pix[r][c] = 8'h80;
                    1: pix[r][c] = (c < 8) ? 8'h00 : 8'hFF;
                    2: pix[r][c] = 8'(c);
                    default: pix[r][c] = (r == 1 && c == 1) ? 8'd100 : 8'd0;
                endcase
        for (int i = 0; i < NW; i++) expv[i] = '0;
        case (kind)
            1: begin
                expv[5] = 32'h000000FF; expv[6] = 32'hFF000000;
                expv[9] = 32'h000000FF; expv[10] = 32'hFF000000;
            end
            2: begin
                expv[4] = 32'h00080808; expv[5] = 32'h08080808;
                expv[6] = 32'h08080808; expv[7] = 32'h08080800;
                expv[8] = 32'h00080808; expv[9] = 32'h08080808;
                expv[10] = 32'h08080808; expv[11] = 32'h08080800;
            end
            3: begin
                expv[4] = 32'h0000C800;
                expv[8] = 32'h00C8C800;
            end
            default: ;
        endcase
    endtask

    task automatic run_frame(input string name, input bit poke);
        int w0, r0, d0, f0, cyc;
        w0 = wcnt; r0 = rcnt; d0 = ndone; f0 = nfin;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({name, "_busy"}, 32'(busy), 32'd1);
        if (poke) begin
            repeat (20) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_finish"}, 32'(finish), 32'd1);
        @(negedge clk);
        chk({name, "_busy_off"}, 32'(busy), 32'd0);
        chk({name, "_done_cnt"}, 32'(ndone - d0), 32'd1);
        chk({name, "_fin_cnt"}, 32'(nfin - f0), 32'd1);
        chk({name, "_writes"}, 32'(wcnt - w0), 32'(NW));
        chk({name, "_reads"}, 32'(rcnt - r0), 32'(NW));
        for (int i = 0; i < NW; i++)
            chk($sformatf("%s_w%0d", name, i), wmem[i], expv[i]);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_en", 32'(cache_en), 32'd0);
        chk("rst_we", 32'(cache_we), 32'd0);
        chk("rst_di", cache_di, 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        set_frame(0); run_frame("flat", 1'b0);
        set_frame(1); run_frame("step", 1'b0);
        set_frame(2); run_frame("ramp", 1'b0);
        set_frame(3); run_frame("dot", 1'b0);
        set_frame(1); run_frame("poke", 1'b1);

        set_frame(2);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_en", 32'(cache_en), 32'd0);
        chk("mid_we", 32'(cache_we), 32'd0);
        chk("mid_di", cache_di, 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_finish", 32'(finish), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        run_frame("after", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
